// File: rtl/ready_req_scheduler_if.sv
// Handshake bundle between the ready/request scheduler and its environment
// (shared resource on one side, N requesters on the other).
// master: the scheduler itself; slave: resource + requesters (or a bench).
interface ready_req_scheduler_if #(
    parameter int N_CLIENTS = 4,
    parameter int IDW       = $clog2(N_CLIENTS)
);
    logic                 res_ready;
    logic                 res_request;
    logic [N_CLIENTS-1:0] cl_pending;
    logic [N_CLIENTS-1:0] cl_request;
    logic [N_CLIENTS-1:0] grant;
    logic                 busy;
    logic                 timeout;
    logic [IDW-1:0]       err_id;
    logic                 ready_lost;

    modport master (
        input  res_ready, cl_pending, cl_request,
        output res_request, grant, busy, timeout, err_id, ready_lost
    );

    modport slave (
        output res_ready, cl_pending, cl_request,
        input  res_request, grant, busy, timeout, err_id, ready_lost
    );
endinterface

// File: rtl/ready_req_scheduler.sv
// Round-robin scheduler: forwards each resource-ready pulse to one pending
// client as a one-cycle grant, then forwards that client's request back to
// the resource as res_request.
// Optional macro READY_REQ_SCHED_TIMEOUT_EN: when defined, the client must
// answer within 1..WINDOW cycles after its grant, otherwise timeout pulses and
// err_id records the client. When undefined, WAIT lasts until the request.
//
// state | meaning
// IDLE  | waiting for a ready (new or buffered) and a pending client
// GRANT | one-cycle grant pulse to the selected client
// WAIT  | waiting for the selected client's request
module ready_req_scheduler #(
    parameter int N_CLIENTS = 4,
    parameter int WINDOW    = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ready_req_scheduler_if.master   bus
);
    localparam int IDW = $clog2(N_CLIENTS);

    if (N_CLIENTS < 2 || N_CLIENTS > 16 || WINDOW < 1) begin : g_param_check
        $error("ready_req_scheduler: bad N_CLIENTS/WINDOW");
    end

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT} state_t;

    state_t               state, state_nx;
    logic [IDW-1:0]       ptr, ptr_nx;
    logic [IDW-1:0]       sel, sel_nx, sel_inc;
    logic [IDW-1:0]       winner, idx;
    logic                 found;
    logic                 consume;
    logic                 rdy_pend, rdy_pend_nx;
    logic [N_CLIENTS-1:0] grant_q, grant_nx;
    logic                 res_request_q, res_request_nx;
    logic                 busy_q, busy_nx;
    logic                 lost_q, lost_nx;

`ifdef READY_REQ_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(WINDOW + 1);
    logic [CW-1:0]        cnt, cnt_nx;
    logic                 timeout_q, timeout_nx;
    logic [IDW-1:0]       err_id_q, err_id_nx;
`endif

    // Next round-robin start point after serving sel, wrapping explicitly
    // so non-power-of-two client counts work.
    assign sel_inc = (sel == IDW'(N_CLIENTS - 1)) ? '0 : sel + 1'b1;

    // First pending client searching upward from ptr with wrap-around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            idx = IDW'((int'(ptr) + i) % N_CLIENTS);
            if (!found && bus.cl_pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Next-state, ready buffering and next values of all registered outputs.
    always_comb begin
        state_nx       = state;
        ptr_nx         = ptr;
        sel_nx         = sel;
        grant_nx       = '0;
        res_request_nx = 1'b0;
        lost_nx        = lost_q;
        consume        = 1'b0;
`ifdef READY_REQ_SCHED_TIMEOUT_EN
        cnt_nx         = cnt;
        timeout_nx     = 1'b0;
        err_id_nx      = err_id_q;
`endif
        case (state)
            S_IDLE: begin
                if ((rdy_pend || bus.res_ready) && found) begin
                    consume  = 1'b1;
                    sel_nx   = winner;
                    grant_nx = {{(N_CLIENTS-1){1'b0}}, 1'b1} << winner;
                    state_nx = S_GRANT;
                end
            end
            S_GRANT: begin
                state_nx = S_WAIT;
`ifdef READY_REQ_SCHED_TIMEOUT_EN
                cnt_nx   = CW'(1);
`endif
            end
            S_WAIT: begin
                if (bus.cl_request[sel]) begin
                    res_request_nx = 1'b1;
                    ptr_nx         = sel_inc;
                    state_nx       = S_IDLE;
                end
`ifdef READY_REQ_SCHED_TIMEOUT_EN
                else if (cnt == CW'(WINDOW)) begin
                    timeout_nx = 1'b1;
                    err_id_nx  = sel;
                    ptr_nx     = sel_inc;
                    state_nx   = S_IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
`endif
            end
            default: state_nx = S_IDLE;
        endcase

        // A ready arriving while the buffered one is being consumed takes its
        // place; only an unconsumed buffered ready can be overrun.
        if (consume) begin
            rdy_pend_nx = rdy_pend & bus.res_ready;
        end else begin
            rdy_pend_nx = rdy_pend | bus.res_ready;
            if (rdy_pend && bus.res_ready) lost_nx = 1'b1;
        end

        busy_nx = (state_nx != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ptr           <= '0;
            sel           <= '0;
            rdy_pend      <= 1'b0;
            grant_q       <= '0;
            res_request_q <= 1'b0;
            busy_q        <= 1'b0;
            lost_q        <= 1'b0;
`ifdef READY_REQ_SCHED_TIMEOUT_EN
            cnt           <= '0;
            timeout_q     <= 1'b0;
            err_id_q      <= '0;
`endif
        end else begin
            state         <= state_nx;
            ptr           <= ptr_nx;
            sel           <= sel_nx;
            rdy_pend      <= rdy_pend_nx;
            grant_q       <= grant_nx;
            res_request_q <= res_request_nx;
            busy_q        <= busy_nx;
            lost_q        <= lost_nx;
`ifdef READY_REQ_SCHED_TIMEOUT_EN
            cnt           <= cnt_nx;
            timeout_q     <= timeout_nx;
            err_id_q      <= err_id_nx;
`endif
        end
    end

    assign bus.grant       = grant_q;
    assign bus.res_request = res_request_q;
    assign bus.busy        = busy_q;
    assign bus.ready_lost  = lost_q;
`ifdef READY_REQ_SCHED_TIMEOUT_EN
    assign bus.timeout     = timeout_q;
    assign bus.err_id      = err_id_q;
`else
    assign bus.timeout     = 1'b0;
    assign bus.err_id      = '0;
`endif
endmodule
